// File: rtl/weight_bank_memory.sv
// Multi-bank weight store: NUM_BANKS parallel banks of DEPTH words each.
// Single-bank writes, a zero-fill clear sequence, and a burst reader that
// streams one word from every bank per beat through a 2-entry skid buffer
// under a valid/ready handshake.
module weight_bank_memory #(
  parameter int WEIGHT_WIDTH   = 16,
  parameter int DEPTH          = 121,
  parameter int ADDR_WIDTH     = 7,
  parameter int NUM_BANKS      = 4,
  parameter int BANK_SEL_WIDTH = 2,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_en,
  input  logic [BANK_SEL_WIDTH-1:0]         wr_bank,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]           wr_data,
  output logic                              wr_ready,
  input  logic                              clear_start,
  input  logic                              rd_start,
  input  logic [ADDR_WIDTH-1:0]             rd_base,
  input  logic [LEN_WIDTH-1:0]              rd_len,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_BANKS*WEIGHT_WIDTH-1:0] data_out,
  output logic                              out_last
);

  localparam int WORD_WIDTH = NUM_BANKS * WEIGHT_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

  // One extra bit so DEPTH and NUM_BANKS are representable even when they
  // equal a full power of two of the select widths.
  localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]     DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [BANK_SEL_WIDTH:0] BANKS_EXT = (BANK_SEL_WIDTH + 1)'(NUM_BANKS);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LEN_WIDTH-1:0]  issue_left;

  logic                  rd_pending;
  logic                  rd_pending_last;
  logic [WORD_WIDTH-1:0] bank_word;

  logic [1:0]            buf_count;
  logic [WORD_WIDTH-1:0] buf0_data;
  logic [WORD_WIDTH-1:0] buf1_data;
  logic                  buf0_last;
  logic                  buf1_last;

  logic                  pop;
  logic [2:0]            slots_used;
  logic                  rd_issue;
  logic                  rd_in_range;
  logic                  clear_we;
  logic                  wr_ok;
  logic                  last_accept;

  assign busy      = (state != ST_IDLE);
  assign wr_ready  = (state != ST_CLEAR);
  assign out_valid = (buf_count != 2'd0);
  assign out_last  = out_valid && buf0_last;
  assign data_out  = buf0_data;

  assign pop         = out_valid && out_ready;
  assign last_accept = pop && buf0_last;

  // Slots taken once this cycle's pop leaves: buffered beats plus the read
  // already in flight. A new read may only issue if it will have a home.
  assign slots_used  = 3'(buf_count) + 3'(rd_pending) - 3'(pop);
  assign rd_issue    = (state == ST_READ) && (issue_left != '0) && (slots_used < 3'd2);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);

  assign clear_we = (state == ST_CLEAR);
  assign wr_ok    = wr_en && wr_ready
                    && ({1'b0, wr_addr} < DEPTH_EXT)
                    && ({1'b0, wr_bank} < BANKS_EXT);

  // Control FSM: clear sweep, burst address sequencing and beat accounting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      clr_addr   <= '0;
      rd_addr    <= '0;
      issue_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
          end else if (rd_start && (rd_len != '0)) begin
            state      <= ST_READ;
            rd_addr    <= rd_base;
            issue_left <= rd_len;
          end
        end
        ST_CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state    <= ST_IDLE;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + ADDR_WIDTH'(1);
          end
        end
        ST_READ: begin
          if (rd_issue) begin
            rd_addr    <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_WIDTH'(1);
            issue_left <= issue_left - LEN_WIDTH'(1);
          end
          if (last_accept) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Track the read in flight through the bank output register, tagging the final one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pending      <= 1'b0;
      rd_pending_last <= 1'b0;
    end else begin
      rd_pending      <= rd_issue;
      rd_pending_last <= rd_issue && (issue_left == LEN_WIDTH'(1));
    end
  end

  // Bank storage: clear sweep has priority, reads see pre-write contents.
  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic [WEIGHT_WIDTH-1:0] mem [DEPTH];
    logic [WEIGHT_WIDTH-1:0] rd_q;
    logic                    bank_wr;

    assign bank_wr = wr_ok && (wr_bank == BANK_SEL_WIDTH'(k));

    // Synchronous write port and one-cycle-latency read port for this bank.
    always_ff @(posedge clk) begin
      if (clear_we) begin
        mem[clr_addr] <= '0;
      end else if (bank_wr) begin
        mem[wr_addr] <= wr_data;
      end
      if (rd_issue) begin
        rd_q <= rd_in_range ? mem[rd_addr] : '0;
      end
    end

    assign bank_word[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] = rd_q;
  end

  // Two-entry skid buffer; entry 0 is always the beat presented on data_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_count <= 2'd0;
      buf0_data <= '0;
      buf1_data <= '0;
      buf0_last <= 1'b0;
      buf1_last <= 1'b0;
    end else begin
      case ({rd_pending, pop})
        2'b10: begin
          if (buf_count == 2'd0) begin
            buf0_data <= bank_word;
            buf0_last <= rd_pending_last;
          end else begin
            buf1_data <= bank_word;
            buf1_last <= rd_pending_last;
          end
          buf_count <= buf_count + 2'd1;
        end
        2'b01: begin
          buf0_data <= buf1_data;
          buf0_last <= buf1_last;
          buf_count <= buf_count - 2'd1;
        end
        2'b11: begin
          if (buf_count == 2'd1) begin
            buf0_data <= bank_word;
            buf0_last <= rd_pending_last;
          end else begin
            buf0_data <= buf1_data;
            buf0_last <= buf1_last;
            buf1_data <= bank_word;
            buf1_last <= rd_pending_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_bank_memory.sv
// Self-checking bench for weight_bank_memory: directed steps plus random
// writes/bursts, checked against an array model of the bank contents.
module tb_weight_bank_memory;

  localparam int W     = 16;
  localparam int DEPTH = 121;
  localparam int NB    = 4;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [1:0]    wr_bank;
  logic [6:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic          wr_ready;
  logic          clear_start;
  logic          rd_start;
  logic [6:0]    rd_base;
  logic [7:0]    rd_len;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [NB*W-1:0] data_out;
  logic          out_last;

  int checks;
  int fails;

  logic [W-1:0] model_mem [NB][DEPTH];

  weight_bank_memory dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_bank     (wr_bank),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .clear_start (clear_start),
    .rd_start    (rd_start),
    .rd_base     (rd_base),
    .rd_len      (rd_len),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .out_last    (out_last)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] model_word(input int addr);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < NB; k++) w[k*W +: W] = model_mem[k][addr];
    return w;
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    logic r;
    r = 1'b1;
    if (mode == 1) begin
      case (cyc % 6)
        1, 2, 4: r = 1'b0;
        default: r = 1'b1;
      endcase
    end else if (mode == 2) begin
      r = 1'($urandom_range(0, 1));
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NB; k++)
      for (int a = 0; a < DEPTH; a++) model_mem[k][a] = '0;
  endtask

  // One write cycle; the model follows only writes that land in real storage
  task automatic applyStimulus(input int bank, input int addr, input logic [W-1:0] data);
    wr_en   = 1'b1;
    wr_bank = 2'(bank);
    wr_addr = 7'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
    if (addr < DEPTH && bank < NB) model_mem[bank][addr] = data;
  endtask

  // Run a burst and compare every accepted beat against the model snapshot
  task automatic runBurst(input int base, input int len, input int mode, input string tag, input bit collide);
    logic [63:0] exp_q[$];
    logic [63:0] held_data;
    logic        held_last;
    bit          prev_stall;
    int          got, cyc, first_cyc, last_cyc;
    for (int i = 0; i < len; i++) exp_q.push_back(model_word((base + i) % DEPTH));
    rd_base  = 7'(base);
    rd_len   = 8'(len);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    got = 0; cyc = 0; first_cyc = -1; last_cyc = -1; prev_stall = 0;
    held_data = '0; held_last = 1'b0;
    while (got < len && cyc < 1000) begin
      if (collide) begin
        wr_en   = (cyc == 0);
        wr_bank = 2'd2;
        wr_addr = 7'd10;
        wr_data = 16'h7FFF;
      end
      out_ready = ready_for(mode, cyc);
      if (prev_stall) begin
        checkOutput($sformatf("%s stall valid", tag), 64'(out_valid), 64'd1);
        checkOutput($sformatf("%s stall data", tag), data_out, held_data);
        checkOutput($sformatf("%s stall last", tag), 64'(out_last), 64'(held_last));
      end
      if (out_valid && out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        checkOutput($sformatf("%s beat%0d data", tag, got), data_out, exp_q[got]);
        checkOutput($sformatf("%s beat%0d last", tag, got), 64'(out_last), 64'(got == len - 1));
        got++;
      end
      prev_stall = out_valid && !out_ready;
      held_data  = data_out;
      held_last  = out_last;
      tick();
      cyc++;
    end
    wr_en     = 1'b0;
    out_ready = 1'b1;
    checkOutput($sformatf("%s beat count", tag), 64'(got), 64'(len));
    checkOutput($sformatf("%s busy after", tag), 64'(busy), 64'd0);
    checkOutput($sformatf("%s valid after", tag), 64'(out_valid), 64'd0);
    if (mode == 0) begin
      checkOutput($sformatf("%s first beat latency", tag), 64'(first_cyc), 64'd2);
      checkOutput($sformatf("%s no bubbles", tag), 64'(last_cyc - first_cyc), 64'(len - 1));
    end
    if (collide) model_mem[2][10] = 16'h7FFF;
  endtask

  // Wait out a clear sequence, counting busy cycles and watching for stray beats
  task automatic waitClear(input string tag, input bit poke);
    int  n;
    bit  saw_valid;
    n = 0; saw_valid = 0;
    while (busy && n < 300) begin
      if (poke) begin
        rd_start = (n == 10);
        rd_len   = 8'd3;
        wr_en    = (n == 20);
        wr_bank  = 2'd1;
        wr_addr  = 7'd3;
        wr_data  = 16'h1234;
        if (n == 0) checkOutput($sformatf("%s wr_ready low", tag), 64'(wr_ready), 64'd0);
      end
      if (out_valid) saw_valid = 1;
      tick();
      n++;
    end
    rd_start = 1'b0;
    wr_en    = 1'b0;
    checkOutput($sformatf("%s busy cycles", tag), 64'(n), 64'(DEPTH));
    checkOutput($sformatf("%s no beats", tag), 64'(saw_valid), 64'd0);
    model_clear();
    tick();
    tick();
    checkOutput($sformatf("%s idle after", tag), 64'(busy), 64'd0);
    checkOutput($sformatf("%s no read started", tag), 64'(out_valid), 64'd0);
  endtask

  initial begin
    int got, n;
    checks = 0; fails = 0;
    reset = 1'b1; wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    clear_start = 1'b0; rd_start = 1'b0; rd_base = '0; rd_len = '0; out_ready = 1'b1;
    model_clear();
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_last", 64'(out_last), 64'd0);
    checkOutput("reset data_out", data_out, 64'd0);
    checkOutput("reset wr_ready", 64'(wr_ready), 64'd1);

    // Zero-length read request is ignored
    rd_base = 7'd0; rd_len = 8'd0; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    checkOutput("len0 ignored", 64'(busy), 64'd0);

    // Clear with a read pulse and a write poked in while busy; both ignored
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    waitClear("clear", 1'b1);
    runBurst(0, DEPTH, 0, "zeros", 1'b0);

    // Fill every bank with k*256+a
    for (int k = 0; k < NB; k++)
      for (int a = 0; a < DEPTH; a++) applyStimulus(k, a, 16'(k * 256 + a));

    runBurst(5, 3, 0, "base5", 1'b0);
    runBurst(119, 4, 0, "wrap", 1'b0);
    runBurst(40, 6, 1, "stall", 1'b0);

    // Read/write collision returns old data, then the new value is visible
    runBurst(10, 1, 0, "collide", 1'b1);
    runBurst(10, 1, 0, "reread", 1'b0);

    // Out-of-range write must not disturb anything
    applyStimulus(0, 121, 16'hBEEF);
    runBurst(0, DEPTH, 0, "after oob", 1'b0);

    // Random writes and bursts with random backpressure
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++)
        applyStimulus($urandom_range(0, NB - 1), $urandom_range(0, 127), 16'($urandom));
      runBurst($urandom_range(0, DEPTH - 1), $urandom_range(1, 20), 2, $sformatf("rand%0d", r), 1'b0);
    end

    // Reset in the middle of an 8-beat burst
    rd_base = 7'd0; rd_len = 8'd8; out_ready = 1'b1; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    got = 0; n = 0;
    while (got < 2 && n < 50) begin
      if (out_valid && out_ready) got++;
      tick();
      n++;
    end
    checkOutput("midreset beats before", 64'(got), 64'd2);
    reset = 1'b1;
    #1;
    checkOutput("midreset valid", 64'(out_valid), 64'd0);
    checkOutput("midreset busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("midreset stays quiet", 64'(out_valid), 64'd0);

    // Contents survive reset
    runBurst(100, 10, 0, "post reset", 1'b0);

    // Clear and read requested together: clear wins
    rd_base = 7'd0; rd_len = 8'd5; clear_start = 1'b1; rd_start = 1'b1;
    tick();
    clear_start = 1'b0; rd_start = 1'b0;
    checkOutput("clr+rd busy", 64'(busy), 64'd1);
    checkOutput("clr+rd wr_ready", 64'(wr_ready), 64'd0);
    waitClear("clr+rd", 1'b0);
    runBurst(0, DEPTH, 0, "final zeros", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/weight_bank_memory.md
Name: weight_bank_memory

Overview:
Parametrised multi-bank weight store for the neural-network datapath, replacing the single-bank weight memory. It provides NUM_BANKS parallel banks, each DEPTH x WEIGHT_WIDTH. Writes go to one bank per cycle. A sequenced burst read streams one word from every bank per beat, with a valid/ready handshake to the MAC array. A multi-cycle clear command zeroes all banks.

Parameters:
WEIGHT_WIDTH, 16, signed weight word width
DEPTH, 121, words per bank
ADDR_WIDTH, 7, address width; must satisfy 2^ADDR_WIDTH >= DEPTH
NUM_BANKS, 4, number of parallel banks (>=1)
BANK_SEL_WIDTH, 2, bank-select width; must satisfy 2^BANK_SEL_WIDTH >= NUM_BANKS
LEN_WIDTH, 8, burst-length field width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
wr_en  in  1  write request
wr_bank  in  BANK_SEL_WIDTH  target bank
wr_addr  in  ADDR_WIDTH  target word
wr_data  in  WEIGHT_WIDTH  signed write data
wr_ready  out  1  write accepted this cycle when high
clear_start  in  1  one-cycle pulse; starts a zero-fill of all banks
rd_start  in  1  one-cycle pulse; starts a burst read
rd_base  in  ADDR_WIDTH  burst start address
rd_len  in  LEN_WIDTH  number of beats in the burst
busy  out  1  high in CLEAR or READ state
out_valid  out  1  data_out holds a valid beat
out_ready  in  1  consumer accepts the beat
data_out  out  NUM_BANKS*WEIGHT_WIDTH  bank k occupies bits [k*WEIGHT_WIDTH +: WEIGHT_WIDTH], signed
out_last  out  1  marks the final beat of a burst; qualified by out_valid

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE; all counters are cleared.
  - busy=0, out_valid=0, out_last=0, data_out=0, wr_ready=1.
  - The skid buffer is emptied.
  - Memory contents are NOT cleared by reset; software issues clear_start.
  - Reset mid-burst or mid-clear aborts the operation immediately; no further beats are produced.
- FSM states: IDLE, CLEAR, READ.
- IDLE:
  - clear_start -> CLEAR.
  - Otherwise, rd_start with rd_len!=0 -> READ; rd_base and rd_len are latched.
  - rd_start with rd_len==0 is ignored.
  - If clear_start and rd_start arrive in the same cycle, clear wins and the read is dropped.
- CLEAR:
  - One address per cycle; every bank's address 0..DEPTH-1 is written with 0.
  - Takes exactly DEPTH cycles, then -> IDLE.
  - wr_ready=0 for the whole state; writes presented during CLEAR are dropped.
- READ:
  - Read address starts at rd_base and increments by 1 per issued read.
  - Wrap-around: DEPTH-1 is followed by 0.
  - Exactly rd_len reads are issued.
  - The state returns to IDLE once the final beat has been accepted (out_valid && out_ready && out_last).
- start pulses (clear_start, rd_start) are ignored while busy=1.
- Read pipeline:
  - Banks are synchronous-read with 1-cycle latency, feeding a 2-entry skid buffer.
  - A read issues when the buffer has a free slot counting in-flight reads.
  - Latency: rd_start sampled at edge N; first address issued in cycle N+1; out_valid rises after edge N+2.
  - With out_ready held high, throughput is 1 beat/cycle with no bubbles.
- Handshake:
  - A beat transfers on a cycle where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, data_out and out_last are held stable.
  - out_valid never drops without a transfer.
- Writes:
  - Accepted when wr_en && wr_ready; the write lands at the clock edge.
  - Writes are allowed in IDLE and READ.
  - Writes with wr_addr>=DEPTH or wr_bank>=NUM_BANKS are silently dropped.
- Read/write collision (same bank and address in the same cycle): the read returns the old data (read-before-write).
- Arithmetic: no arithmetic on data. Address wrap uses a compare against DEPTH-1, not a power-of-2 mask.

Test Plan:
- Reset, then clear_start -> busy high for exactly 121 cycles. A subsequent burst (base 0, len 121) returns all zeros, with out_last only on beat 121.
- Write bank k, addr a with value (k*256+a) for all k, a. Burst base 5, len 3, out_ready=1 -> beats at addresses 5, 6, 7. First out_valid occurs 2 cycles after rd_start; no gaps between beats.
- Burst base 119, len 4 -> addresses 119, 120, 0, 1 (wrap). out_last is asserted on the 4th beat only.
- Burst len 6 with out_ready toggled 1,0,0,1,0,1... -> no beat lost or duplicated, data stable while stalled, order preserved.
- Write 0x7FFF to bank 2, addr 10 in the same cycle its read issues -> that beat shows the old value; a re-read shows 0x7FFF. A write with wr_addr=121 leaves memory unchanged.
- Assert reset mid-burst (after beat 2 of 8) -> out_valid=0 and busy=0 immediately. clear_start and rd_start in the same cycle -> CLEAR is entered and the read is dropped.
